// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / duty-meter pair.
package pwm_pkg;

    // Counter width shared by the generator and the meter.
    localparam int PWM_CW = 16;

    // Period-counter value at which a missing rising edge is declared stuck.
    localparam int PWM_TIMEOUT = 1000;

    // Duty-meter state: waiting for a first rise, inside the high phase,
    // inside the low phase.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } meter_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a history flop,
// producing the synced level and single-cycle rise/fall strobes.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // s1/s2 resolve metastability; s3 holds the previous synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of an external PWM waveform in clk cycles,
// publishing each result with a one-cycle valid strobe and flagging a
// waveform that stops toggling (stuck high or stuck low).
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int CW      = PWM_CW,
    parameter int TIMEOUT = PWM_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    output logic [CW-1:0] high_time,
    output logic [CW-1:0] period,
    output logic          valid,
    output logic          stuck,
    output logic          stuck_level
);

    // TIMEOUT must fit the counters and leave room for a real period.
    if ((TIMEOUT < 2) || (longint'(TIMEOUT) > ((longint'(1) << CW) - 1))) begin : g_bad_timeout
        $error("pwm_duty_meter: TIMEOUT out of range 2..2^CW-1");
    end

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic level;
    logic rise;
    logic fall;

    pwm_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pwm_in),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    meter_state_e  state_q, state_d;
    logic [CW-1:0] cnt_period_q, cnt_period_d;
    logic [CW-1:0] cnt_high_q, cnt_high_d;
    logic [CW-1:0] high_time_q, high_time_d;
    logic [CW-1:0] period_q, period_d;
    logic          valid_q, valid_d;
    logic          stuck_q, stuck_d;
    logic          stuck_level_q, stuck_level_d;

    // State, counters and published results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_period_q  <= '0;
            cnt_high_q    <= '0;
            high_time_q   <= '0;
            period_q      <= '0;
            valid_q       <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_period_q  <= cnt_period_d;
            cnt_high_q    <= cnt_high_d;
            high_time_q   <= high_time_d;
            period_q      <= period_d;
            valid_q       <= valid_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    // Next state: a rise closes a period; reaching TIMEOUT without a rise
    // reports the stuck level and parks in IDLE until the waveform resumes.
    always_comb begin
        state_d       = state_q;
        cnt_period_d  = cnt_period_q;
        cnt_high_d    = cnt_high_q;
        high_time_d   = high_time_q;
        period_d      = period_q;
        valid_d       = 1'b0;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d      = ST_HIGH;
                    cnt_period_d = CNT_ONE;
                    cnt_high_d   = CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (cnt_period_q == TIMEOUT_C) begin
                    state_d       = ST_IDLE;
                    stuck_d       = 1'b1;
                    stuck_level_d = level;
                    high_time_d   = level ? TIMEOUT_C : '0;
                    period_d      = TIMEOUT_C;
                    valid_d       = 1'b1;
                end else begin
                    cnt_period_d = cnt_period_q + CNT_ONE;
                    if (fall) begin
                        state_d = ST_LOW;
                    end else begin
                        cnt_high_d = cnt_high_q + CNT_ONE;
                    end
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d      = ST_HIGH;
                    high_time_d  = cnt_high_q;
                    period_d     = cnt_period_q;
                    valid_d      = 1'b1;
                    stuck_d      = 1'b0;
                    cnt_period_d = CNT_ONE;
                    cnt_high_d   = CNT_ONE;
                end else if (cnt_period_q == TIMEOUT_C) begin
                    state_d       = ST_IDLE;
                    stuck_d       = 1'b1;
                    stuck_level_d = level;
                    high_time_d   = level ? TIMEOUT_C : '0;
                    period_d      = TIMEOUT_C;
                    valid_d       = 1'b1;
                end else begin
                    cnt_period_d = cnt_period_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign high_time   = high_time_q;
    assign period      = period_q;
    assign valid       = valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule
